// File: rtl/mpu_pkg.sv
// Shared MPU operand-bus definitions: element geometry, loader states, element offset helper.
package mpu_pkg;

    localparam int ELEM_W = 8;
    localparam int DIM    = 5;
    localparam int N      = DIM * DIM;
    localparam int MAT_W  = ELEM_W * N;
    localparam int CNT_W  = $clog2(N);

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        CHECK,
        HOLD
    } state_t;

    // Bit offset of element (row i, col j) inside a packed operand bus.
    function automatic int elem_off(input int i, input int j);
        return ELEM_W * (i + DIM * j);
    endfunction

endpackage

// File: rtl/mpu_sum_acc.sv
// Running sum modulo 2^ELEM_W with synchronous clear (priority) and enable.
// Latency: sum reflects din one cycle after en. Backpressure: none, follows en.
// Purpose-built for the loader checksum; used only when MPU_LOADER_CHECKSUM_EN is defined.
module mpu_sum_acc
    import mpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [ELEM_W-1:0] din,
    output logic [ELEM_W-1:0] sum
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum + din;
        end
    end

endmodule

// File: rtl/mpu_matrix_loader.sv
// Assembles matrices A then B (DIM x DIM, ELEM_W-bit) from a byte stream onto packed operand buses.
// Latency: out_valid the cycle after the last B byte (one more with MPU_LOADER_CHECKSUM_EN check byte).
// Backpressure: in_ready drops while holding A/B; out_ready low holds the operands indefinitely.
module mpu_matrix_loader
    import mpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [ELEM_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [MAT_W-1:0]  matrix_a,
    output logic [MAT_W-1:0]  matrix_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept;
    logic             sum_ok;

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    // flush wins over a byte offered in the same cycle
    assign accept    = in_valid && in_ready && !flush;

`ifdef MPU_LOADER_CHECKSUM_EN
    logic [ELEM_W-1:0] acc;
    logic              acc_clr;
    logic              acc_en;
    logic              err_q;

    assign acc_en  = accept && (state == LOAD_A || state == LOAD_B);
    assign acc_clr = flush || (state_nxt == LOAD_A && state != LOAD_A);
    assign sum_ok  = (in_data == acc);

    mpu_sum_acc u_sum_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .en    (acc_en),
        .din   (in_data),
        .sum   (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && (state == CHECK) && !sum_ok;
        end
    end

    assign err = err_q;
`else
    assign sum_ok = 1'b1;
    assign err    = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush) begin
            state_nxt = LOAD_A;
            cnt_nxt   = '0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (accept) begin
                        if (cnt == CNT_LAST) begin
                            cnt_nxt   = '0;
                            state_nxt = LOAD_B;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        if (cnt == CNT_LAST) begin
                            cnt_nxt = '0;
`ifdef MPU_LOADER_CHECKSUM_EN
                            state_nxt = CHECK;
`else
                            state_nxt = HOLD;
`endif
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        state_nxt = sum_ok ? HOLD : LOAD_A;
                        cnt_nxt   = '0;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_nxt = LOAD_A;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = LOAD_A;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOAD_A;
            cnt      <= '0;
            matrix_a <= '0;
            matrix_b <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // stream byte k lands at [ELEM_W*k +: ELEM_W]; elements overwrite in place
            if (accept && state == LOAD_A) begin
                matrix_a[ELEM_W*cnt +: ELEM_W] <= in_data;
            end
            if (accept && state == LOAD_B) begin
                matrix_b[ELEM_W*cnt +: ELEM_W] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Randomised scoreboard bench for mpu_matrix_loader; exercises the checksum path when MPU_LOADER_CHECKSUM_EN is defined.
module tb_mpu_matrix_loader;
    import mpu_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic [ELEM_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [MAT_W-1:0]  matrix_a;
    logic [MAT_W-1:0]  matrix_b;
    logic              out_valid;
    logic              out_ready;
    logic              err;

    mpu_matrix_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .matrix_a  (matrix_a),
        .matrix_b  (matrix_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    typedef struct packed {
        logic [MAT_W-1:0] a;
        logic [MAT_W-1:0] b;
    } exp_t;

    exp_t        exp_q[$];
    int          err_exp;
    int          vectors;
    int          miscompares;
    int          cyc;
    int          ovld_cyc;
    logic        ovld_prev;
    logic [7:0]  stream_b[2*N];

`ifdef MPU_LOADER_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [MAT_W-1:0] act, input logic [MAT_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference: a full load maps stream byte k to element k of A, then k of B.
    task automatic push_expected();
        exp_t e;
        for (int k = 0; k < N; k++) begin
            e.a[8*k +: 8] = stream_b[k];
            e.b[8*k +: 8] = stream_b[N + k];
        end
        exp_q.push_back(e);
    endtask

    task automatic send_load(input int gap_pct, input bit bad_sum);
        logic [7:0] sum;
        sum = 8'h00;
        for (int k = 0; k < 2*N; k++) begin
            for (int g = 0; g < 8 && $urandom_range(99) < gap_pct; g++) begin
                in_valid = 1'b0;
                cycle();
            end
            in_valid = 1'b1;
            in_data  = stream_b[k];
            sum      = sum + stream_b[k];
            chk("in_ready_load", MAT_W'(in_ready), MAT_W'(1));
            if (k == 2*N-1 && EXTRA == 0) push_expected();
            cycle();
        end
`ifdef MPU_LOADER_CHECKSUM_EN
        for (int g = 0; g < 8 && $urandom_range(99) < gap_pct; g++) begin
            in_valid = 1'b0;
            cycle();
        end
        in_valid = 1'b1;
        in_data  = bad_sum ? sum + 8'h01 : sum;
        chk("in_ready_check", MAT_W'(in_ready), MAT_W'(1));
        if (bad_sum) err_exp++;
        else push_expected();
        cycle();
`else
        if (bad_sum) $display("note: checksum disabled, bad_sum ignored");
`endif
        in_valid = 1'b0;
    endtask

    task automatic fill_random();
        for (int k = 0; k < 2*N; k++) stream_b[k] = 8'($urandom);
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < N; k++) begin
            stream_b[k]     = 8'(k + 1);
            stream_b[N + k] = 8'(N - k);
        end
    endtask

    // Monitor: every out_valid cycle must show the scoreboard head; pop on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !ovld_prev) ovld_cyc = cyc;
            ovld_prev = out_valid;
            if (out_valid) begin
                chk("sb_not_empty", MAT_W'(exp_q.size() != 0), MAT_W'(1));
                if (exp_q.size() != 0) begin
                    chk("matrix_a", matrix_a, exp_q[0].a);
                    chk("matrix_b", matrix_b, exp_q[0].b);
                    chk("hold_in_ready", MAT_W'(in_ready), MAT_W'(0));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (err) begin
                chk("err_expected", MAT_W'(err_exp > 0), MAT_W'(1));
                if (err_exp > 0) err_exp--;
            end
        end else begin
            ovld_prev = 1'b0;
        end
    end

    initial begin
        int t0;
        vectors     = 0;
        miscompares = 0;
        err_exp     = 0;
        cyc         = 0;
        ovld_cyc    = -1;
        ovld_prev   = 1'b0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        out_ready   = 1'b1;

        #3;
        chk("rst_matrix_a", matrix_a, '0);
        chk("rst_matrix_b", matrix_b, '0);
        chk("rst_out_valid", MAT_W'(out_valid), MAT_W'(0));
        chk("rst_err", MAT_W'(err), MAT_W'(0));
        chk("rst_in_ready", MAT_W'(in_ready), MAT_W'(1));
        #19 rst_n = 1'b1;
        cycle();

        // Ramp load, free-flowing consumer: latency and single-cycle out_valid
        fill_ramp();
        t0 = cyc;
        send_load(0, 1'b0);
        chk("s1_out_valid", MAT_W'(out_valid), MAT_W'(1));
        chk("s1_a_first", MAT_W'(matrix_a[7:0]), MAT_W'(1));
        chk("s1_a_last", MAT_W'(matrix_a[199:192]), MAT_W'(25));
        chk("s1_b_first", MAT_W'(matrix_b[7:0]), MAT_W'(25));
        cycle();
        chk("s1_latency", MAT_W'(ovld_cyc - t0), MAT_W'(2*N + EXTRA));
        chk("s1_vld_one_cycle", MAT_W'(out_valid), MAT_W'(0));
        chk("s1_in_ready_after", MAT_W'(in_ready), MAT_W'(1));

        // Consumer stalls for 10 cycles
        out_ready = 1'b0;
        send_load(0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("s2_hold_valid", MAT_W'(out_valid), MAT_W'(1));
            cycle();
        end
        out_ready = 1'b1;
        cycle();
        chk("s2_vld_drop", MAT_W'(out_valid), MAT_W'(0));
        chk("s2_in_ready", MAT_W'(in_ready), MAT_W'(1));

        // Random data with ~50% input gaps
        for (int r = 0; r < 3; r++) begin
            fill_random();
            send_load(50, 1'b0);
            cycle();
        end

        // flush after 30 bytes drops the concurrent byte and the partial load
        for (int k = 0; k < 30; k++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            cycle();
        end
        in_data = 8'($urandom);
        flush   = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        cycle();
        chk("s4_no_vld", MAT_W'(out_valid), MAT_W'(0));
        fill_random();
        send_load(20, 1'b0);
        cycle();

`ifdef MPU_LOADER_CHECKSUM_EN
        for (int k = 0; k < 2*N; k++) stream_b[k] = 8'h01;
        send_load(0, 1'b0);
        chk("s5_good_vld", MAT_W'(out_valid), MAT_W'(1));
        cycle();
        send_load(0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("s5_bad_no_vld", MAT_W'(out_valid), MAT_W'(0));
            chk("s5_bad_in_ready", MAT_W'(in_ready), MAT_W'(1));
            cycle();
        end
        chk("s5_err_seen", MAT_W'(err_exp), MAT_W'(0));
        fill_random();
        send_load(0, 1'b0);
        cycle();
`endif

        // Async reset in the middle of B
        fill_random();
        for (int k = 0; k < N + 10; k++) begin
            in_valid = 1'b1;
            in_data  = stream_b[k];
            cycle();
        end
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #2;
        chk("s6_a_zero", matrix_a, '0);
        chk("s6_b_zero", matrix_b, '0);
        chk("s6_vld_zero", MAT_W'(out_valid), MAT_W'(0));
        chk("s6_err_zero", MAT_W'(err), MAT_W'(0));
        #2 rst_n = 1'b1;
        cycle();
        fill_random();
        send_load(30, 1'b0);
        cycle();
        cycle();

        chk("sb_drained", MAT_W'(exp_q.size()), MAT_W'(0));
        chk("err_drained", MAT_W'(err_exp), MAT_W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
